// File: rtl/conn_pkg.sv
// conn_pkg -- shared definitions for the link connection handshake.
//
// Holds the message codes carried on the rx/tx message channels, the
// connection state encodings and the interrupt status bit indices. Both
// the responder and the initiator-side logic import this package, so the
// initiator can compare its state against ST_ESTABLISHED directly.
package conn_pkg;

    // Message codes (3 bits, same encoding on rx_type and tx_type)
    localparam logic [2:0] MSG_NONE   = 3'd0;
    localparam logic [2:0] MSG_SYN    = 3'd1;
    localparam logic [2:0] MSG_SYNACK = 3'd2;
    localparam logic [2:0] MSG_ACK    = 3'd3;
    localparam logic [2:0] MSG_FIN    = 3'd4;
    localparam logic [2:0] MSG_FINACK = 3'd5;
    localparam logic [2:0] MSG_RST    = 3'd6;

    // Connection state encodings; codes 6..15 are unused
    typedef enum logic [3:0] {
        ST_CLOSED      = 4'd0,
        ST_LISTEN      = 4'd1,
        ST_SYN_RCVD    = 4'd2,
        ST_ESTABLISHED = 4'd3,
        ST_CLOSE_WAIT  = 4'd4,
        ST_LAST_ACK    = 4'd5
    } conn_state_t;

    // Interrupt status bit indices
    localparam int INT_ESTABLISHED = 0;
    localparam int INT_PEER_CLOSED = 1;
    localparam int INT_TIMEOUT     = 2;
    localparam int INT_RST_RCVD    = 3;

endpackage

// File: rtl/conn_timeout_ctr.sv
// conn_timeout_ctr -- handshake timeout counter.
//
// Counts while en is high and raises tc once the count reaches
// TIMEOUT_CYCLES-1. The count holds at the terminal value so a caller
// that cannot act on tc immediately still sees it on later cycles.
// clr has priority over en and returns the count to zero.
//
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   clr  in  synchronous clear of the count
//   en   in  count enable
//   tc   out terminal count reached (count == TIMEOUT_CYCLES-1)
module conn_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [15:0] TC_VAL = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && !tc) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign tc = (count_reg == TC_VAL);

endmodule

// File: rtl/conn_responder.sv
// conn_responder -- responder end of the link connection handshake.
//
// Accepts SYN/ACK/FIN/RST messages from the initiator, drives the matching
// replies through a single-entry TX buffer, and exposes the connection
// state plus a sticky write-1-to-clear interrupt status vector.
//
// Build option: define CONN_RESP_RETRY_EN to resend SYNACK up to MAX_RETRY
// times on a SYN_RCVD timeout before giving up. Without it the first
// timeout returns to LISTEN and MAX_RETRY has no effect.
//
// Ports:
//   clk          in  clock, rising edge
//   rst          in  asynchronous active-high reset
//   listen_en    in  host enable; leave CLOSED and accept connections
//   close_req    in  host close request (acted on in CLOSE_WAIT)
//   rx_valid     in  incoming message valid
//   rx_ready     out block can consume a message
//   rx_type[2:0] in  incoming message code
//   tx_valid     out outgoing message valid
//   tx_ready     in  sink accepts the outgoing message
//   tx_type[2:0] out outgoing message code
//   conn_state   out current state encoding
//   established  out conn_state == ESTABLISHED
//   int_status   out sticky flags: [0] established, [1] peer closed,
//                    [2] timeout, [3] RST received
//   int_clear    in  write-1-to-clear for int_status
module conn_responder
    import conn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       listen_en,
    input  logic       close_req,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [2:0] rx_type,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [2:0] tx_type,
    output logic [3:0] conn_state,
    output logic       established,
    output logic [3:0] int_status,
    input  logic [3:0] int_clear
);

`ifdef CONN_RESP_RETRY_EN
    localparam logic [15:0] RETRY_LIMIT = 16'(MAX_RETRY);
`else
    // A zero limit means the first timeout gives up straight away.
    localparam logic [15:0] RETRY_LIMIT = 16'd0;
`endif

    conn_state_t state_reg;
    logic        tx_valid_reg;
    logic [2:0]  tx_type_reg;
    logic [3:0]  int_status_reg;
    logic [15:0] retry_reg;

    logic        rx_fire;
    logic        rst_msg;
    logic        syn_accept;
    logic        ack_fire;
    logic        fin_fire;
    logic        timer_tc;
    logic        timeout_hit;
    logic        retry_load;
    logic        give_up;
    logic        timer_clr;
    logic        timer_en;
    logic [3:0]  int_set;

    assign rx_ready    = (state_reg != ST_CLOSED) && !tx_valid_reg;
    assign rx_fire     = rx_valid && rx_ready;
    assign tx_valid    = tx_valid_reg;
    assign tx_type     = tx_type_reg;
    assign conn_state  = state_reg;
    assign established = (state_reg == ST_ESTABLISHED);
    assign int_status  = int_status_reg;

    always_comb begin
        // RST is acted on as soon as it is presented, even while a reply
        // is still sitting in the TX buffer; that is the only way to abort
        // a stalled handshake. It is formally consumed once rx_ready rises.
        rst_msg     = rx_valid && (rx_type == MSG_RST) && (state_reg != ST_CLOSED);
        ack_fire    = rx_fire && (rx_type == MSG_ACK);
        fin_fire    = rx_fire && (rx_type == MSG_FIN);
        syn_accept  = (state_reg == ST_LISTEN) && listen_en
                      && rx_fire && (rx_type == MSG_SYN);
        // An ACK in the same cycle as the timeout wins.
        timeout_hit = (state_reg == ST_SYN_RCVD) && timer_tc && !ack_fire && !rst_msg;
        // A resend waits for the previous SYNACK to drain; the counter
        // holds at terminal count meanwhile.
        retry_load  = timeout_hit && (retry_reg < RETRY_LIMIT) && !tx_valid_reg;
        give_up     = timeout_hit && (retry_reg >= RETRY_LIMIT);
        timer_clr   = syn_accept || retry_load;
        timer_en    = (state_reg == ST_SYN_RCVD);

        int_set                  = '0;
        int_set[INT_ESTABLISHED] = (state_reg == ST_SYN_RCVD) && ack_fire;
        int_set[INT_PEER_CLOSED] = (state_reg == ST_ESTABLISHED) && fin_fire;
        int_set[INT_TIMEOUT]     = give_up;
        int_set[INT_RST_RCVD]    = rst_msg;
    end

    conn_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .en  (timer_en),
        .tc  (timer_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_CLOSED;
            tx_valid_reg   <= 1'b0;
            tx_type_reg    <= MSG_NONE;
            int_status_reg <= '0;
            retry_reg      <= '0;
        end else begin
            // Set beats clear when both hit the same bit.
            int_status_reg <= (int_status_reg & ~int_clear) | int_set;

            if (tx_valid_reg && tx_ready) begin
                tx_valid_reg <= 1'b0;
            end

            // Every load below happens only with the TX buffer empty, so it
            // never collides with the handshake clear above.
            if (rst_msg) begin
                state_reg    <= listen_en ? ST_LISTEN : ST_CLOSED;
                tx_valid_reg <= 1'b0;
                tx_type_reg  <= MSG_NONE;
            end else begin
                case (state_reg)
                    ST_CLOSED: begin
                        if (listen_en) begin
                            state_reg <= ST_LISTEN;
                        end
                    end
                    ST_LISTEN: begin
                        if (!listen_en) begin
                            state_reg <= ST_CLOSED;
                        end else if (syn_accept) begin
                            state_reg    <= ST_SYN_RCVD;
                            tx_valid_reg <= 1'b1;
                            tx_type_reg  <= MSG_SYNACK;
                            retry_reg    <= '0;
                        end
                    end
                    ST_SYN_RCVD: begin
                        if (ack_fire) begin
                            state_reg <= ST_ESTABLISHED;
                        end else if (retry_load) begin
                            tx_valid_reg <= 1'b1;
                            tx_type_reg  <= MSG_SYNACK;
                            retry_reg    <= retry_reg + 16'd1;
                        end else if (give_up) begin
                            state_reg <= ST_LISTEN;
                        end
                    end
                    ST_ESTABLISHED: begin
                        if (fin_fire) begin
                            state_reg    <= ST_CLOSE_WAIT;
                            tx_valid_reg <= 1'b1;
                            tx_type_reg  <= MSG_ACK;
                        end
                    end
                    ST_CLOSE_WAIT: begin
                        if (close_req && !tx_valid_reg) begin
                            state_reg    <= ST_LAST_ACK;
                            tx_valid_reg <= 1'b1;
                            tx_type_reg  <= MSG_FIN;
                        end
                    end
                    ST_LAST_ACK: begin
                        if (ack_fire) begin
                            state_reg <= listen_en ? ST_LISTEN : ST_CLOSED;
                        end
                    end
                    default: begin
                        state_reg <= ST_CLOSED;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conn_responder.sv
// tb_conn_responder -- self-checking bench for conn_responder.
//
// A table of per-cycle vectors walks the happy path, backpressure and the
// close sequence; hand-written sequences cover the timeout (with or without
// CONN_RESP_RETRY_EN), RST with a reply pending, and asynchronous reset.
module tb_conn_responder;

    localparam int TIMEOUT = 16;
`ifdef CONN_RESP_RETRY_EN
    localparam int RETRIES = 2;
`else
    localparam int RETRIES = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       listen_en;
    logic       close_req;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] rx_type;
    logic       tx_valid;
    logic       tx_ready;
    logic [2:0] tx_type;
    logic [3:0] conn_state;
    logic       established;
    logic [3:0] int_status;
    logic [3:0] int_clear;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    conn_responder dut (
        .clk         (clk),
        .rst         (rst),
        .listen_en   (listen_en),
        .close_req   (close_req),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_type     (rx_type),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_type     (tx_type),
        .conn_state  (conn_state),
        .established (established),
        .int_status  (int_status),
        .int_clear   (int_clear)
    );

    typedef struct {
        logic       listen;
        logic       close;
        logic       rxv;
        logic [2:0] rxt;
        logic       txr;
        logic [3:0] clr;
        logic [3:0] st;
        logic       txv;
        logic [2:0] txt;
        logic       rxr;
        logic [3:0] intr;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act != exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        close_req = 1'b0;
        rx_valid  = 1'b0;
        rx_type   = 3'd0;
        tx_ready  = 1'b1;
        int_clear = 4'd0;
    endtask

    function automatic vec_t mk(input logic listen, input logic close, input logic rxv,
                                input logic [2:0] rxt, input logic txr, input logic [3:0] clr,
                                input logic [3:0] st, input logic txv, input logic [2:0] txt,
                                input logic rxr, input logic [3:0] intr);
        vec_t v;
        v.listen = listen; v.close = close; v.rxv = rxv; v.rxt = rxt; v.txr = txr;
        v.clr = clr; v.st = st; v.txv = txv; v.txt = txt; v.rxr = rxr; v.intr = intr;
        return v;
    endfunction

    initial begin
        int n;
        int synack_cnt;

        //          listen close rxv rxt   txr clr     st    txv txt   rxr int
        vecs[0]  = mk(1, 0, 0, 3'd0, 1, 4'h0, 4'd1, 0, 3'd0, 1, 4'h0); // CLOSED->LISTEN
        vecs[1]  = mk(1, 0, 1, 3'd1, 0, 4'h0, 4'd2, 1, 3'd2, 0, 4'h0); // SYN -> SYNACK
        vecs[2]  = mk(1, 0, 0, 3'd0, 0, 4'h0, 4'd2, 1, 3'd2, 0, 4'h0); // stalled, stable
        vecs[3]  = mk(1, 0, 0, 3'd0, 1, 4'h0, 4'd2, 0, 3'd0, 1, 4'h0); // handshake
        vecs[4]  = mk(1, 0, 1, 3'd3, 1, 4'h0, 4'd3, 0, 3'd0, 1, 4'h1); // ACK -> EST
        vecs[5]  = mk(1, 0, 1, 3'd4, 0, 4'h0, 4'd4, 1, 3'd3, 0, 4'h3); // FIN -> tx ACK
        vecs[6]  = mk(1, 0, 0, 3'd0, 1, 4'h0, 4'd4, 0, 3'd0, 1, 4'h3); // ACK drained
        vecs[7]  = mk(1, 1, 0, 3'd0, 0, 4'h0, 4'd5, 1, 3'd4, 0, 4'h3); // close -> tx FIN
        vecs[8]  = mk(1, 0, 0, 3'd0, 1, 4'h0, 4'd5, 0, 3'd0, 1, 4'h3); // FIN drained
        vecs[9]  = mk(1, 0, 1, 3'd3, 1, 4'h0, 4'd1, 0, 3'd0, 1, 4'h3); // ACK -> LISTEN
        vecs[10] = mk(1, 0, 0, 3'd0, 1, 4'h3, 4'd1, 0, 3'd0, 1, 4'h0); // W1C
        vecs[11] = mk(1, 0, 1, 3'd3, 1, 4'h0, 4'd1, 0, 3'd0, 1, 4'h0); // stray ACK ignored
        vecs[12] = mk(0, 0, 0, 3'd0, 1, 4'h0, 4'd0, 0, 3'd0, 0, 4'h0); // listen off

        rst       = 1'b1;
        listen_en = 1'b0;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_state", conn_state, 0);
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_tx_type", tx_type, 0);
        chk("reset_rx_ready", rx_ready, 0);
        chk("reset_int", int_status, 0);
        step();
        chk("closed_hold", conn_state, 0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            listen_en = vecs[i].listen;
            close_req = vecs[i].close;
            rx_valid  = vecs[i].rxv;
            rx_type   = vecs[i].rxt;
            tx_ready  = vecs[i].txr;
            int_clear = vecs[i].clr;
            step();
            $display("vec %0d: state=%0d tx_valid=%0d tx_type=%0d rx_ready=%0d int=%b",
                     i, conn_state, tx_valid, tx_type, rx_ready, int_status);
            chk($sformatf("vec%0d_state", i), conn_state, vecs[i].st);
            chk($sformatf("vec%0d_established", i), established, (vecs[i].st == 4'd3) ? 1 : 0);
            chk($sformatf("vec%0d_tx_valid", i), tx_valid, vecs[i].txv);
            if (vecs[i].txv) chk($sformatf("vec%0d_tx_type", i), tx_type, vecs[i].txt);
            chk($sformatf("vec%0d_rx_ready", i), rx_ready, vecs[i].rxr);
            chk($sformatf("vec%0d_int", i), int_status, vecs[i].intr);
        end
        idle_inputs();

        // ---------------- timeout (with optional retries) ----------------
        listen_en = 1'b1;
        step();
        rx_valid = 1'b1;
        rx_type  = 3'd1;
        step();
        rx_valid = 1'b0;
        rx_type  = 3'd0;
        synack_cnt = (tx_valid && tx_type == 3'd2) ? 1 : 0;
        n = 0;
        while (conn_state != 4'd1 && n < 200) begin
            step();
            n++;
            if (tx_valid && tx_type == 3'd2 && conn_state == 4'd2) synack_cnt++;
        end
        $display("timeout: cycles=%0d synacks=%0d state=%0d int=%b",
                 n, synack_cnt, conn_state, int_status);
        chk("timeout_cycles", n, TIMEOUT * (1 + RETRIES));
        chk("timeout_synacks", synack_cnt, 1 + RETRIES);
        chk("timeout_state", conn_state, 1);
        chk("timeout_int2", int_status[2], 1);
        int_clear = 4'h4;
        step();
        int_clear = 4'h0;
        chk("timeout_int_cleared", int_status, 0);

        // ---------------- RST with SYNACK pending ----------------
        tx_ready = 1'b0;
        rx_valid = 1'b1;
        rx_type  = 3'd1;
        step();
        rx_valid = 1'b0;
        chk("rst_pre_pending", tx_valid, 1);
        rx_valid  = 1'b1;
        rx_type   = 3'd6;
        int_clear = 4'h8;
        step();
        rx_valid  = 1'b0;
        rx_type   = 3'd0;
        int_clear = 4'h0;
        $display("rst: state=%0d tx_valid=%0d int=%b", conn_state, tx_valid, int_status);
        chk("rst_tx_dropped", tx_valid, 0);
        chk("rst_state", conn_state, 1);
        chk("rst_int3_set_wins", int_status[3], 1);
        int_clear = 4'h8;
        step();
        int_clear = 4'h0;
        chk("rst_int3_cleared", int_status[3], 0);

        // ---------------- async reset mid-ESTABLISHED ----------------
        tx_ready = 1'b1;
        rx_valid = 1'b1;
        rx_type  = 3'd1;
        step();
        rx_valid = 1'b0;
        step();
        rx_valid = 1'b1;
        rx_type  = 3'd3;
        step();
        rx_valid = 1'b0;
        rx_type  = 3'd0;
        chk("pre_reset_established", established, 1);
        #3 rst = 1'b1;
        #1;
        $display("async reset: state=%0d tx_valid=%0d rx_ready=%0d int=%b",
                 conn_state, tx_valid, rx_ready, int_status);
        chk("areset_state", conn_state, 0);
        chk("areset_established", established, 0);
        chk("areset_tx_valid", tx_valid, 0);
        chk("areset_rx_ready", rx_ready, 0);
        chk("areset_int", int_status, 0);
        step();
        rst = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
